mem_read_scheduler: RTL

- Parametrised successor to the single-slot read-RAM request queue in the out-of-order core.
- Buffers tagged RAM read requests (address + instruction number) in an in-order FIFO.
- Issues up to RD_PORTS requests per cycle onto the block-RAM read ports.
- Returns tagged read data so the instruction queue can update the matching entry without address bookkeeping.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/read_rsp_pipe.sv | 81 ++++++++
 rtl/mem_read_scheduler.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the tagged RAM read scheduler.
// Default widths match the out-of-order core's data RAM.
package mem_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_TAG_W  = 8;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_TAG_W-1:0]  tag;
  } read_req_t;

  typedef struct packed {
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_DATA_W-1:0] data;
  } read_rsp_t;

  function automatic int unsigned wrap_add(
    input int unsigned p,
    input int unsigned k,
    input int unsigned depth
  );
    int unsigned s;
    s = p + k;
    if (s >= depth) s = s - depth;
    return s;
  endfunction

endpackage

// File: rtl/read_rsp_pipe.sv
// Per-port response pipeline: carries the issued tag alongside
// the RAM read and captures the data word when the RAM presents it.
module read_rsp_pipe #(
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 8,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [TAG_W-1:0]  iss_tag,
  input  logic [DATA_W-1:0] ram_data,
  output logic              rsp_valid,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic [DATA_W-1:0] rsp_data
);

  logic              v_q, v_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  if (LATENCY == 0) begin : g_lat0
    // Combinational RAM: data is valid in the issue cycle
    always_comb begin
      v_d    = iss_valid;
      tag_d  = tag_q;
      data_d = data_q;
      if (iss_valid) begin
        tag_d  = iss_tag;
        data_d = ram_data;
      end
    end
  end else begin : g_lat1
    logic             s1_v_q, s1_v_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    // Registered RAM: hold the tag one cycle, capture data after
    always_comb begin
      s1_v_d   = iss_valid;
      s1_tag_d = iss_valid ? iss_tag : s1_tag_q;
      v_d      = s1_v_q && !flush;
      tag_d    = tag_q;
      data_d   = data_q;
      if (s1_v_q) begin
        tag_d  = s1_tag_q;
        data_d = ram_data;
      end
    end

    // First stage register, cleared by reset
    always_ff @(posedge clk) begin
      if (rst) begin
        s1_v_q   <= 1'b0;
        s1_tag_q <= '0;
      end else begin
        s1_v_q   <= s1_v_d;
        s1_tag_q <= s1_tag_d;
      end
    end
  end

  // Output stage register
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

  // A flush kills the response landing in the flush cycle too
  assign rsp_valid = v_q && !flush;
  assign rsp_tag   = tag_q;
  assign rsp_data  = data_q;

endmodule

// File: rtl/mem_read_scheduler.sv
// In-order tagged RAM read request FIFO issuing up to RD_PORTS/cycle.
// Optional counters: define MEM_READ_SCHEDULER_STATS_EN.
module mem_read_scheduler
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int TAG_W       = MEM_TAG_W,
  parameter int DEPTH       = 11,
  parameter int RD_PORTS    = 2,
  parameter int RAM_LATENCY = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         hold,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [TAG_W-1:0]             req_tag,
  output logic [RD_PORTS*ADDR_W-1:0]   ram_addr,
  input  logic [RD_PORTS*DATA_W-1:0]   ram_data,
  output logic [RD_PORTS-1:0]          rsp_valid,
  output logic [RD_PORTS*TAG_W-1:0]    rsp_tag,
  output logic [RD_PORTS*DATA_W-1:0]   rsp_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [31:0]                  stat_issued,
  output logic [31:0]                  stat_stall
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam int NW = $clog2(RD_PORTS+1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [TAG_W-1:0]  tag;
  } ent_t;

  ent_t                       mem_q [DEPTH];
  logic [PW-1:0]              head_q, head_d;
  logic [PW-1:0]              tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;
  logic [RD_PORTS*ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [NW-1:0]              n;
  logic [PW-1:0]              idx;
  logic                       accept;
  logic                       issue_en;
  logic [RD_PORTS-1:0]        iss_v;
  logic [RD_PORTS*TAG_W-1:0]  iss_tag;

  assign req_ready = count_q < CW'(DEPTH);
  assign accept    = req_valid && req_ready && !flush;
  assign issue_en  = !hold && !flush && !rst;

  // Pick up to RD_PORTS oldest entries; idle ports keep last address
  always_comb begin
    n          = '0;
    idx        = '0;
    iss_v      = '0;
    iss_tag    = '0;
    ram_addr_d = ram_addr_q;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (issue_en && count_q > CW'(p)) begin
        idx = PW'(wrap_add(32'(head_q), p, DEPTH));
        iss_v[p] = 1'b1;
        iss_tag[p*TAG_W +: TAG_W] = mem_q[idx].tag;
        ram_addr_d[p*ADDR_W +: ADDR_W] = mem_q[idx].addr;
        n = n + NW'(1);
      end
    end
  end

  assign ram_addr = ram_addr_d;

  // Pointer and occupancy update; flush empties the queue
  always_comb begin
    head_d  = PW'(wrap_add(32'(head_q), 32'(n), DEPTH));
    tail_d  = accept ? PW'(wrap_add(32'(tail_q), 1, DEPTH)) : tail_q;
    count_d = count_q + CW'(accept) - CW'(n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Queue control state
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ram_addr_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      ram_addr_q <= ram_addr_d;
    end
  end

  // Entry storage, written at the tail on accept
  always_ff @(posedge clk) begin
    if (accept && !rst) begin
      mem_q[tail_q] <= '{addr: req_addr, tag: req_tag};
    end
  end

  assign count = count_q;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
    read_rsp_pipe #(
      .DATA_W  (DATA_W),
      .TAG_W   (TAG_W),
      .LATENCY (RAM_LATENCY)
    ) u_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .iss_valid (iss_v[p]),
      .iss_tag   (iss_tag[p*TAG_W +: TAG_W]),
      .ram_data  (ram_data[p*DATA_W +: DATA_W]),
      .rsp_valid (rsp_valid[p]),
      .rsp_tag   (rsp_tag[p*TAG_W +: TAG_W]),
      .rsp_data  (rsp_data[p*DATA_W +: DATA_W])
    );
  end

`ifdef MEM_READ_SCHEDULER_STATS_EN
  logic [31:0] stat_issued_q, stat_issued_d;
  logic [31:0] stat_stall_q, stat_stall_d;

  // Issue and stall counters; only reset clears them
  always_comb begin
    stat_issued_d = stat_issued_q + 32'(n);
    stat_stall_d  = stat_stall_q + 32'(req_valid && !req_ready);
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_issued = '0;
  assign stat_stall  = '0;
`endif

endmodule
